// File: rtl/dma_utils_pkg.sv
// Shared AXI4 types, burst/response encodings and helpers used by the DMA
// data path and the memory target that terminates it.
package dma_utils_pkg;

    typedef logic [31:0] axi_addr_t;
    typedef logic [7:0]  axi_alen_t;
    typedef logic [2:0]  axi_size_t;
    typedef logic [1:0]  axi_burst_t;
    typedef logic [1:0]  axi_error_t;
    typedef logic [3:0]  axi_tid_t;
    typedef logic [31:0] axi_data_t;
    typedef logic [3:0]  axi_strb_t;

    localparam axi_burst_t BURST_FIXED = 2'd0;
    localparam axi_burst_t BURST_INCR  = 2'd1;
    localparam axi_burst_t BURST_WRAP  = 2'd2;
    localparam axi_error_t RESP_OKAY   = 2'd0;
    localparam axi_error_t RESP_SLVERR = 2'd2;

    typedef struct packed {
        axi_tid_t   awid;
        axi_addr_t  awaddr;
        axi_alen_t  awlen;
        axi_size_t  awsize;
        axi_burst_t awburst;
        logic       awvalid;
        axi_data_t  wdata;
        axi_strb_t  wstrb;
        logic       wlast;
        logic       wvalid;
        logic       bready;
        axi_tid_t   arid;
        axi_addr_t  araddr;
        axi_alen_t  arlen;
        axi_size_t  arsize;
        axi_burst_t arburst;
        logic       arvalid;
        logic       rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic       awready;
        logic       wready;
        axi_tid_t   bid;
        axi_error_t bresp;
        logic       bvalid;
        logic       arready;
        axi_tid_t   rid;
        axi_data_t  rdata;
        axi_error_t rresp;
        logic       rlast;
        logic       rvalid;
    } s_axi_miso_t;

    // Only FIXED and INCR bursts are served by the memory target.
    function automatic logic burst_supported(input axi_burst_t burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/axi_mem_slave_addr_gen.sv
// Per-channel address arithmetic: next beat address, array word index,
// out-of-range detection and unsupported-burst detection.
module axi_mem_addr_gen
    import dma_utils_pkg::*;
#(
    parameter int        MEM_WORDS = 1024,
    parameter axi_addr_t BASE_ADDR = '0,
    parameter bit        ERR_OOR   = 1'b1,
    localparam int       IDX_W     = $clog2(MEM_WORDS)
) (
    input  axi_addr_t        addr,
    input  axi_size_t        size,
    input  axi_burst_t       burst,
    output axi_addr_t        next_addr,
    output logic [IDX_W-1:0] word_idx,
    output logic             oor_err,
    output logic             burst_err
);

    localparam axi_addr_t MEM_BYTES = axi_addr_t'(MEM_WORDS) << 2'd2;

    axi_addr_t offset_s;

    // Map byte address to word index; with ERR_OOR=0 the index wraps naturally.
    always_comb begin
        offset_s  = addr - BASE_ADDR;
        word_idx  = offset_s[IDX_W+1:2];
        oor_err   = ERR_OOR && (offset_s >= MEM_BYTES);
        burst_err = !burst_supported(burst);
        case (burst)
            BURST_INCR: next_addr = addr + (axi_addr_t'(1) << size);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 burst memory target for the DMA master port. Independent write and
// read FSMs share one register array (one write port, one read port).
module axi_mem_slave
    import dma_utils_pkg::*;
#(
    parameter int        MEM_WORDS = 1024,
    parameter axi_addr_t BASE_ADDR = '0,
    parameter bit        ERR_OOR   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    axi_data_t mem_r [MEM_WORDS];

    w_state_t   w_state_r;
    axi_addr_t  w_addr_r;
    axi_alen_t  w_len_r, w_cnt_r;
    axi_size_t  w_size_r;
    axi_burst_t w_burst_r;
    axi_tid_t   w_id_r;
    logic       w_err_r, w_over_r;
    logic       awready_r, wready_r, bvalid_r;
    axi_error_t bresp_r;
    axi_tid_t   bid_r;

    axi_addr_t        w_next_addr_s;
    logic [IDX_W-1:0] w_idx_s;
    logic             w_oor_s, w_berr_s, w_hs_s, w_beat_err_s, w_len_err_s, w_we_s;

    r_state_t   r_state_r;
    axi_addr_t  r_next_r;
    axi_alen_t  r_len_r, r_cnt_r;
    axi_size_t  r_size_r;
    axi_burst_t r_burst_r;
    logic       arready_r, rvalid_r, rlast_r;
    axi_data_t  rdata_r;
    axi_error_t rresp_r;
    axi_tid_t   rid_r;

    axi_addr_t        r_addr_s, r_next_addr_s;
    axi_size_t        r_size_s;
    axi_burst_t       r_burst_s;
    logic [IDX_W-1:0] r_idx_s;
    logic             r_oor_s, r_berr_s, r_err_s, ar_hs_s, r_adv_s;
    axi_data_t        r_word_s;

    axi_mem_addr_gen #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .ERR_OOR(ERR_OOR)) u_aw_gen (
        .addr(w_addr_r), .size(w_size_r), .burst(w_burst_r),
        .next_addr(w_next_addr_s), .word_idx(w_idx_s), .oor_err(w_oor_s), .burst_err(w_berr_s)
    );

    axi_mem_addr_gen #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR), .ERR_OOR(ERR_OOR)) u_ar_gen (
        .addr(r_addr_s), .size(r_size_s), .burst(r_burst_s),
        .next_addr(r_next_addr_s), .word_idx(r_idx_s), .oor_err(r_oor_s), .burst_err(r_berr_s)
    );

    // Write beat qualification: once the beat count overruns awlen nothing more is stored.
    always_comb begin
        w_hs_s       = (w_state_r == W_DATA) && wready_r && axi_mosi_i.wvalid;
        w_beat_err_s = w_oor_s || w_berr_s || w_over_r;
        w_we_s       = w_hs_s && !w_beat_err_s;
        if (axi_mosi_i.wlast) begin
            w_len_err_s = (w_cnt_r != w_len_r);
        end else begin
            w_len_err_s = (w_cnt_r == w_len_r);
        end
    end

    // Write channel FSM with registered AW/W/B outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_r <= W_IDLE;
            w_addr_r  <= 32'h0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_size_r  <= 3'd0;
            w_burst_r <= BURST_FIXED;
            w_id_r    <= 4'd0;
            w_err_r   <= 1'b0;
            w_over_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            bid_r     <= 4'd0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (axi_mosi_i.awvalid && awready_r) begin
                        w_addr_r  <= axi_mosi_i.awaddr;
                        w_len_r   <= axi_mosi_i.awlen;
                        w_size_r  <= axi_mosi_i.awsize;
                        w_burst_r <= axi_mosi_i.awburst;
                        w_id_r    <= axi_mosi_i.awid;
                        w_cnt_r   <= 8'd0;
                        w_err_r   <= 1'b0;
                        w_over_r  <= 1'b0;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b1;
                        w_state_r <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        w_addr_r <= w_next_addr_s;
                        w_cnt_r  <= w_cnt_r + 8'd1;
                        if (axi_mosi_i.wlast) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bid_r     <= w_id_r;
                            bresp_r   <= (w_err_r || w_beat_err_s || w_len_err_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_r <= W_RESP;
                        end else begin
                            w_err_r  <= w_err_r || w_beat_err_s || w_len_err_s;
                            w_over_r <= w_over_r || w_len_err_s;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_mosi_i.bready) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Single write port of the array; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_mosi_i.wstrb[b]) begin
                    mem_r[w_idx_s][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
                end
            end
        end
    end

    // In idle the AR request itself is the fetch address so the first beat lands one cycle later.
    always_comb begin
        ar_hs_s = (r_state_r == R_IDLE) && arready_r && axi_mosi_i.arvalid;
        r_adv_s = (r_state_r == R_DATA) && rvalid_r && axi_mosi_i.rready;
        if (r_state_r == R_IDLE) begin
            r_addr_s  = axi_mosi_i.araddr;
            r_size_s  = axi_mosi_i.arsize;
            r_burst_s = axi_mosi_i.arburst;
        end else begin
            r_addr_s  = r_next_r;
            r_size_s  = r_size_r;
            r_burst_s = r_burst_r;
        end
        r_err_s  = r_oor_s || r_berr_s;
        r_word_s = r_err_s ? 32'h0 : mem_r[r_idx_s];
    end

    // Read channel FSM; r_next_r always holds the address of the beat to fetch next.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_r <= R_IDLE;
            r_next_r  <= 32'h0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_size_r  <= 3'd0;
            r_burst_r <= BURST_FIXED;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= 32'h0;
            rresp_r   <= RESP_OKAY;
            rid_r     <= 4'd0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        r_next_r  <= r_next_addr_s;
                        r_len_r   <= axi_mosi_i.arlen;
                        r_size_r  <= axi_mosi_i.arsize;
                        r_burst_r <= axi_mosi_i.arburst;
                        r_cnt_r   <= 8'd0;
                        rid_r     <= axi_mosi_i.arid;
                        rdata_r   <= r_word_s;
                        rresp_r   <= r_err_s ? RESP_SLVERR : RESP_OKAY;
                        rlast_r   <= (axi_mosi_i.arlen == 8'd0);
                        rvalid_r  <= 1'b1;
                        arready_r <= 1'b0;
                        r_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_adv_s) begin
                        if (rlast_r) begin
                            rvalid_r  <= 1'b0;
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            r_next_r <= r_next_addr_s;
                            r_cnt_r  <= r_cnt_r + 8'd1;
                            rdata_r  <= r_word_s;
                            rresp_r  <= r_err_s ? RESP_SLVERR : RESP_OKAY;
                            rlast_r  <= ((r_cnt_r + 8'd1) == r_len_r);
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Response bundle is driven purely from registers.
    always_comb begin
        axi_miso_o.awready = awready_r;
        axi_miso_o.wready  = wready_r;
        axi_miso_o.bid     = bid_r;
        axi_miso_o.bresp   = bresp_r;
        axi_miso_o.bvalid  = bvalid_r;
        axi_miso_o.arready = arready_r;
        axi_miso_o.rid     = rid_r;
        axi_miso_o.rdata   = rdata_r;
        axi_miso_o.rresp   = rresp_r;
        axi_miso_o.rlast   = rlast_r;
        axi_miso_o.rvalid  = rvalid_r;
    end

endmodule
